stop_it_ctrl: RTL

- Game-control FSM for the "Stop It" LED game.
- Sits directly upstream of the LED shifter and generates its load, shift and off strobes from the player's go/stop buttons and a slow tick.
- Counts shifts issued and judges whether the player stopped exactly on the target count.
- Drives the win/lose indication, which is shown through LED blanking (blink) and result flags.

---
 rtl/stop_it_pkg.sv | 16 +
 rtl/tick_divider.sv | 42 ++++
 rtl/stop_it_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stop_it_pkg.sv
// rtl/stop_it_pkg.sv - shared types and constants for the Stop It game controller
package stop_it_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        JUDGE = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_e;

    localparam int SHIFT_CNT_W = 5;
    localparam int LED_COUNT   = 16;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - counts enabled ticks modulo DIV and flags the wrapping tick
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic tick_i,
    output logic pulse_o
);

    localparam logic [3:0] LAST = 4'(DIV - 1);

    logic [3:0] cnt_q, cnt_d;

    // Advance on enabled ticks; the tick that wraps the count is the qualified one
    always_comb begin
        cnt_d   = cnt_q;
        pulse_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                pulse_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Divider count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stop_it_ctrl.sv
// rtl/stop_it_ctrl.sv - game FSM driving load/shift/off strobes and judging the stop
module stop_it_ctrl
    import stop_it_pkg::*;
#(
    parameter int TICK_DIV      = 2,
    parameter int TARGET        = 8,
    parameter int BLINK_TOGGLES = 6,
    parameter int HOLD_TICKS    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   go_i,
    input  logic                   stop_i,
    input  logic                   tick_i,
    output logic                   load_o,
    output logic                   shift_o,
    output logic                   off_o,
    output logic                   win_o,
    output logic                   lose_o,
    output logic [SHIFT_CNT_W-1:0] shift_cnt_o
);

    state_e                 state_q, state_d;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]             phase_q, phase_d;
    logic                   load_q, load_d;
    logic                   shift_q, shift_d;
    logic                   off_q, off_d;
    logic                   win_q, win_d;
    logic                   lose_q, lose_d;
    logic                   div_clr;
    logic                   div_run;
    logic                   div_pulse;

    // The divider only runs in RUN and is held at zero otherwise, so RUN always starts fresh
    assign div_run = (state_q == RUN);
    assign div_clr = (state_q != RUN);

    tick_divider #(
        .DIV(TICK_DIV)
    ) u_tick_divider (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (div_clr),
        .en_i   (div_run),
        .tick_i (tick_i),
        .pulse_o(div_pulse)
    );

    // Next-state, counter and output decode; phase counts blink toggles or hold ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = '0;
        shift_d = 1'b0;
        off_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_i) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // stop beats a coinciding shift tick
                if (stop_i) begin
                    state_d = JUDGE;
                end else if (div_pulse && cnt_q < SHIFT_CNT_W'(LED_COUNT)) begin
                    shift_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == SHIFT_CNT_W'(LED_COUNT - 1)) state_d = LOSE;
                end
            end
            JUDGE: begin
                state_d = (cnt_q == SHIFT_CNT_W'(TARGET)) ? WIN : LOSE;
            end
            WIN: begin
                phase_d = phase_q;
                off_d   = off_q;
                if (tick_i) begin
                    phase_d = phase_q + 8'd1;
                    off_d   = ~off_q;
                    if (phase_q == 8'(BLINK_TOGGLES - 1)) begin
                        state_d = IDLE;
                        off_d   = 1'b0;
                    end
                end
            end
            LOSE: begin
                phase_d = phase_q;
                if (tick_i) begin
                    phase_d = phase_q + 8'd1;
                    if (phase_q == 8'(HOLD_TICKS - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        load_d = (state_d == LOAD);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            off_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            load_q  <= load_d;
            shift_q <= shift_d;
            off_q   <= off_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign load_o      = load_q;
    assign shift_o     = shift_q;
    assign off_o       = off_q;
    assign win_o       = win_q;
    assign lose_o      = lose_q;
    assign shift_cnt_o = cnt_q;

endmodule
